// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory load path: the instruction
// word layout and the loader FSM state encoding.
package imem_loader_pkg;

    localparam int instr_width_lp = 32;

    // One instruction word as stored in imem.
    typedef struct packed {
        logic [24:0] operands;
        logic [6:0]  opcode;
    } instruction_s;

    // Loader FSM states. Kept in the package so debug and trace tools can
    // decode the state register by name.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_e;

endpackage

// File: rtl/imem_loader.sv
// Write-side driver for the instruction memory. Accepts a valid/ready stream
// of instruction words and writes them to consecutive imem addresses. It keeps
// the core held in reset until a load session completes.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int addr_width_p = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_start_i,
    input  logic [addr_width_p-1:0] base_addr_i,
    input  logic [addr_width_p:0]   count_i,
    input  logic                    data_v_i,
    input  instruction_s            data_i,
    output logic                    ready_o,
    output logic                    imem_wen_o,
    output logic [addr_width_p-1:0] imem_addr_o,
    output instruction_s            imem_instruction_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [addr_width_p:0]   words_written_o,
    output logic                    core_hold_o
);

    localparam logic [addr_width_p:0] count_one_lp = (addr_width_p + 1)'(1);

    loader_state_e             state_q;
    logic [addr_width_p-1:0]   addr_q;
    logic [addr_width_p:0]     remaining_q;
    logic [addr_width_p:0]     written_q;
    logic                      wen_q;
    logic [addr_width_p-1:0]   waddr_q;
    instruction_s              wdata_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      hold_q;

    // Ready depends on state only, so a host may hold data_v_i off ready_o
    // without creating a combinational loop.
    assign ready_o = (state_q == LOAD);

    // Session FSM, the three counters and the registered write stage.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register here samples the values from before this edge.
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            written_q   <= '0;
            wen_q       <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            hold_q      <= 1'b1;
        end else begin
            // The write enable and done pulse are single-cycle by default;
            // the address and data registers keep their last values.
            wen_q  <= 1'b0;
            done_q <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (load_start_i) begin
                        addr_q      <= base_addr_i;
                        remaining_q <= count_i;
                        written_q   <= '0;
                        hold_q      <= 1'b1;
                        busy_q      <= 1'b1;
                        if (count_i == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= LOAD;
                        end
                    end
                end

                LOAD: begin
                    if (data_v_i) begin
                        wen_q       <= 1'b1;
                        waddr_q     <= addr_q;
                        wdata_q     <= data_i;
                        // Address wraps naturally at 2**addr_width_p.
                        addr_q      <= addr_q + 1'b1;
                        remaining_q <= remaining_q - 1'b1;
                        written_q   <= written_q + 1'b1;
                        // The final write lands in the same cycle as DONE.
                        if (remaining_q == count_one_lp) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    hold_q  <= 1'b0;
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign imem_wen_o         = wen_q;
    assign imem_addr_o        = waddr_q;
    assign imem_instruction_o = wdata_q;
    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign words_written_o    = written_q;
    assign core_hold_o        = hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader with a 16-entry address space. Each load
// session is predicted from its base, count and the sequence of host words:
// the i-th accepted word must be written to (base + i) mod 16 one cycle after
// it is accepted. A bench-side imem captures the write port for readback.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int aw_lp    = 4;
    localparam int depth_lp = 1 << aw_lp;

    logic               clk = 1'b0;
    logic               reset;
    logic               load_start_i;
    logic [aw_lp-1:0]   base_addr_i;
    logic [aw_lp:0]     count_i;
    logic               data_v_i;
    instruction_s       data_i;
    logic               ready_o;
    logic               imem_wen_o;
    logic [aw_lp-1:0]   imem_addr_o;
    instruction_s       imem_instruction_o;
    logic               busy_o;
    logic               done_o;
    logic [aw_lp:0]     words_written_o;
    logic               core_hold_o;

    int checks = 0;
    int errors = 0;

    instruction_s tb_mem  [depth_lp];
    instruction_s ref_mem [depth_lp];

    imem_loader #(.addr_width_p(aw_lp)) dut (
        .clk                (clk),
        .reset              (reset),
        .load_start_i       (load_start_i),
        .base_addr_i        (base_addr_i),
        .count_i            (count_i),
        .data_v_i           (data_v_i),
        .data_i             (data_i),
        .ready_o            (ready_o),
        .imem_wen_o         (imem_wen_o),
        .imem_addr_o        (imem_addr_o),
        .imem_instruction_o (imem_instruction_o),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .words_written_o    (words_written_o),
        .core_hold_o        (core_hold_o)
    );

    always #5 clk = ~clk;

    // Instruction memory model driven by the loader's write port.
    always @(posedge clk) begin
        if (imem_wen_o) tb_mem[imem_addr_o] <= imem_instruction_o;
    end

    // A count above 2**aw_lp is outside the legal range of the loader.
    always @(posedge clk) begin
        if (!reset && load_start_i && !busy_o)
            assert (count_i <= (aw_lp + 1)'(depth_lp))
            else $error("FAIL illegal_count: observed %0d allowed max %0d", count_i, depth_lp);
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Outputs expected whenever the loader is idle with no session running.
    task automatic check_idle(input string tag, input logic hold, input int written);
        check({tag, "_busy"},  busy_o, 1'b0);
        check({tag, "_ready"}, ready_o, 1'b0);
        check({tag, "_done"},  done_o, 1'b0);
        check({tag, "_wen"},   imem_wen_o, 1'b0);
        check({tag, "_hold"},  core_hold_o, hold);
        check({tag, "_words"}, words_written_o, written);
    endtask

    // Run one complete session.
    // mode 0: data_v_i always high; mode 1: repeating 1,0,0,1,0,1; mode 2: random.
    // inject: pulse load_start_i with different parameters during LOAD and DONE.
    task automatic run_session(input string tag, input int base, input int cnt,
                               input int mode, input bit inject);
        int           accepted;
        int           exp_addr;
        logic         v;
        logic [5:0]   pattern;
        instruction_s word;

        pattern  = 6'b101001;
        accepted = 0;

        load_start_i = 1'b1;
        base_addr_i  = aw_lp'(base);
        count_i      = (aw_lp + 1)'(cnt);
        data_v_i     = 1'b0;
        tick();
        load_start_i = 1'b0;

        check({tag, "_start_busy"},  busy_o, 1'b1);
        check({tag, "_start_hold"},  core_hold_o, 1'b1);
        check({tag, "_start_words"}, words_written_o, 0);
        check({tag, "_start_wen"},   imem_wen_o, 1'b0);
        check({tag, "_start_ready"}, ready_o, cnt != 0);
        check({tag, "_start_done"},  done_o, cnt == 0);

        for (int cyc = 0; cyc < 200 && cnt != 0 && accepted < cnt; cyc++) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = pattern[cyc % 6];
                default: v = 1'($urandom_range(0, 1));
            endcase
            word     = instruction_s'($urandom);
            data_v_i = v;
            data_i   = word;
            if (inject && cyc == 1) begin
                load_start_i = 1'b1;
                base_addr_i  = aw_lp'(base ^ 8);
                count_i      = (aw_lp + 1)'(3);
            end else begin
                load_start_i = 1'b0;
            end
            tick();

            check({tag, "_wen"}, imem_wen_o, v);
            if (v) begin
                exp_addr = (base + accepted) % depth_lp;
                check({tag, "_addr"}, imem_addr_o, exp_addr);
                check({tag, "_data"}, imem_instruction_o, word);
                ref_mem[exp_addr] = word;
                accepted++;
            end
            check({tag, "_words"}, words_written_o, accepted);
            check({tag, "_busy"},  busy_o, 1'b1);
            check({tag, "_hold"},  core_hold_o, 1'b1);
            check({tag, "_done"},  done_o, accepted == cnt);
            check({tag, "_ready"}, ready_o, accepted != cnt);
        end
        check({tag, "_accepted"}, accepted, cnt);

        // The cycle after DONE is IDLE; a start during DONE is ignored.
        data_v_i     = 1'b0;
        load_start_i = inject;
        base_addr_i  = aw_lp'(base ^ 8);
        count_i      = (aw_lp + 1)'(2);
        tick();
        load_start_i = 1'b0;
        check_idle({tag, "_end"}, 1'b0, cnt);

        for (int i = 0; i < cnt; i++) begin
            exp_addr = (base + i) % depth_lp;
            check({tag, "_readback"}, tb_mem[exp_addr], ref_mem[exp_addr]);
        end
    endtask

    initial begin
        reset        = 1'b1;
        load_start_i = 1'b0;
        base_addr_i  = '0;
        count_i      = '0;
        data_v_i     = 1'b0;
        data_i       = '0;

        // Reset values.
        tick();
        tick();
        check_idle("reset", 1'b1, 0);
        check("reset_addr", imem_addr_o, 0);
        check("reset_instr", imem_instruction_o, 0);
        reset = 1'b0;
        tick();
        check_idle("post_reset", 1'b1, 0);

        // Basic load with continuous valid.
        run_session("basic", 3, 5, 0, 1'b0);
        // Address wrap.
        run_session("wrap", 14, 4, 0, 1'b0);
        // Bubbles in the host stream.
        run_session("bubble", 9, 3, 1, 1'b0);
        // Zero-count session, started in the first IDLE cycle after DONE.
        run_session("zero", 6, 0, 0, 1'b0);
        // Starts during LOAD and DONE are ignored.
        run_session("ignore", 2, 6, 0, 1'b1);
        // Full address space.
        run_session("full", 7, depth_lp, 2, 1'b0);

        // Reset in the middle of a session.
        load_start_i = 1'b1;
        base_addr_i  = 4'd5;
        count_i      = 5'd8;
        tick();
        load_start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_v_i = 1'b1;
            data_i   = instruction_s'($urandom);
            tick();
            check("midreset_wen", imem_wen_o, 1'b1);
            check("midreset_addr", imem_addr_o, 5 + i);
        end
        reset = 1'b1;
        tick();
        check_idle("midreset", 1'b1, 0);
        check("midreset_addr0", imem_addr_o, 0);
        reset    = 1'b0;
        data_v_i = 1'b0;
        tick();
        check_idle("after_reset", 1'b1, 0);
        run_session("fresh", 11, 7, 0, 1'b0);

        // Randomized sessions.
        for (int s = 0; s < 8; s++) begin
            run_session("random", int'($urandom_range(0, depth_lp - 1)),
                        int'($urandom_range(0, depth_lp)), 2, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
